// File: rtl/spi_slave_framed.sv
// spi_slave_framed
//   SPI slave front-end for the single-port RAM path. Deserialises command frames
//   {cmd[1:0], payload} from MOSI and, for read-data commands, returns tx_data on MISO.
//   clk is the SPI serial clock; one bit moves per rising edge.
//
//   Ports:
//     clk       SPI serial clock, all logic on the rising edge
//     rst       synchronous active-high reset
//     SS_n      slave select, active low; high aborts/ends any transaction
//     MOSI      serial data in
//     MISO      serial data out, 0 whenever not shifting read data
//     rx_data   last complete frame {cmd[1:0], payload}
//     rx_valid  one-cycle pulse when rx_data updates
//     tx_data   read data from the RAM controller
//     tx_valid  tx_data valid, only sampled while waiting to return read data
//
//   The first bit on the wire after the idle edge selects the path: 0 -> write,
//   1 -> read-address or read-data depending on whether an address was seen.
//   With MSB_FIRST=1 that bit is cmd[1].
module spi_slave_framed #(
    parameter int unsigned DATA_W    = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam int unsigned RX_W   = DATA_W + 2;
    localparam int unsigned CntW   = $clog2(RX_W + 1);
    localparam int unsigned TxCntW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StChkCmd   = 3'd1,
        StWrite    = 3'd2,
        StReadAdd  = 3'd3,
        StReadData = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [RX_W-1:0]   rx_sr_q, rx_sr_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic              frame_done_q, frame_done_d;
    logic [RX_W-1:0]   rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [TxCntW-1:0] tx_cnt_q, tx_cnt_d;
    logic              tx_busy_q, tx_busy_d;
    logic              miso_q, miso_d;
    logic              rd_addr_seen_q, rd_addr_seen_d;

    logic              abort;
    logic              take_bit;
    logic              last_bit;
    logic [RX_W-1:0]   rx_next;

    assign abort    = (state_q != StIdle) && SS_n;
    assign take_bit = (state_q != StIdle) && !frame_done_q;
    assign last_bit = take_bit && (bit_cnt_q == CntW'(RX_W - 1));

    always_comb begin
        if (MSB_FIRST) begin
            rx_next = {rx_sr_q[RX_W-2:0], MOSI};
        end else begin
            rx_next = {MOSI, rx_sr_q[RX_W-1:1]};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:   if (!SS_n) state_d = StChkCmd;
                StChkCmd: begin
                    if (!MOSI) begin
                        state_d = StWrite;
                    end else if (rd_addr_seen_q) begin
                        state_d = StReadData;
                    end else begin
                        state_d = StReadAdd;
                    end
                end
                default:  state_d = state_q;
            endcase
        end
    end

    // Datapath / output next-state logic
    always_comb begin
        rx_sr_d        = rx_sr_q;
        bit_cnt_d      = bit_cnt_q;
        frame_done_d   = frame_done_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        tx_sr_d        = tx_sr_q;
        tx_cnt_d       = tx_cnt_q;
        tx_busy_d      = tx_busy_q;
        miso_d         = 1'b0;
        rd_addr_seen_d = rd_addr_seen_q;

        // A completing frame is delivered even if SS_n rises on the same edge.
        if (last_bit) begin
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            if (state_q == StReadAdd) begin
                rd_addr_seen_d = 1'b1;
            end
        end

        if (abort) begin
            rx_sr_d      = '0;
            bit_cnt_d    = '0;
            frame_done_d = 1'b0;
            tx_sr_d      = '0;
            tx_cnt_d     = '0;
            tx_busy_d    = 1'b0;
            // Only a fully shifted read-data word consumes the address.
            if (tx_cnt_q == TxCntW'(DATA_W)) begin
                rd_addr_seen_d = 1'b0;
            end
        end else if (take_bit) begin
            rx_sr_d   = rx_next;
            bit_cnt_d = bit_cnt_q + CntW'(1);
            if (last_bit) begin
                frame_done_d = 1'b1;
            end
        end else if (state_q == StReadData) begin
            // Frame done: wait for tx_valid, then shift tx_data out.
            if (tx_busy_q) begin
                if (tx_cnt_q == TxCntW'(DATA_W)) begin
                    tx_busy_d      = 1'b0;
                    rd_addr_seen_d = 1'b0;
                end else begin
                    tx_cnt_d = tx_cnt_q + TxCntW'(1);
                    if (MSB_FIRST) begin
                        miso_d  = tx_sr_q[DATA_W-1];
                        tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                    end else begin
                        miso_d  = tx_sr_q[0];
                        tx_sr_d = {1'b0, tx_sr_q[DATA_W-1:1]};
                    end
                end
            end else if ((tx_cnt_q == '0) && tx_valid) begin
                tx_cnt_d  = TxCntW'(1);
                tx_busy_d = 1'b1;
                if (MSB_FIRST) begin
                    miso_d  = tx_data[DATA_W-1];
                    tx_sr_d = {tx_data[DATA_W-2:0], 1'b0};
                end else begin
                    miso_d  = tx_data[0];
                    tx_sr_d = {1'b0, tx_data[DATA_W-1:1]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sr_q        <= '0;
            bit_cnt_q      <= '0;
            frame_done_q   <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            tx_sr_q        <= '0;
            tx_cnt_q       <= '0;
            tx_busy_q      <= 1'b0;
            miso_q         <= 1'b0;
            rd_addr_seen_q <= 1'b0;
        end else begin
            rx_sr_q        <= rx_sr_d;
            bit_cnt_q      <= bit_cnt_d;
            frame_done_q   <= frame_done_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            tx_sr_q        <= tx_sr_d;
            tx_cnt_q       <= tx_cnt_d;
            tx_busy_q      <= tx_busy_d;
            miso_q         <= miso_d;
            rd_addr_seen_q <= rd_addr_seen_d;
        end
    end

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_framed.sv
// Testbench for spi_slave_framed: an MSB-first and an LSB-first instance.
// Expected frames go into per-instance queues; a monitor pops them on rx_valid.
module tb_spi_slave_framed;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       ss_n = 1'b1, mosi = 1'b0, tx_valid = 1'b0, miso, rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic [9:0] rx_data;

    logic       ss_n_l = 1'b1, mosi_l = 1'b0, tx_valid_l = 1'b0, miso_l, rx_valid_l;
    logic [7:0] tx_data_l = 8'h00;
    logic [9:0] rx_data_l;

    logic [9:0] exp_q[$];
    logic [9:0] exp_q_l[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spi_slave_framed #(.DATA_W(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi), .MISO(miso),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
    );

    spi_slave_framed #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .SS_n(ss_n_l), .MOSI(mosi_l), .MISO(miso_l),
        .rx_data(rx_data_l), .rx_valid(rx_valid_l), .tx_data(tx_data_l),
        .tx_valid(tx_valid_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rx_valid pulse must match the next queued frame.
    always @(negedge clk) begin
        if (rx_valid) begin
            if (exp_q.size() == 0) begin
                check("rx_valid_unexpected", 32'(rx_data), 32'h3ff);
            end else begin
                check("rx_frame", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
        if (rx_valid_l) begin
            if (exp_q_l.size() == 0) begin
                check("rx_valid_l_unexpected", 32'(rx_data_l), 32'h3ff);
            end else begin
                check("rx_frame_l", 32'(rx_data_l), 32'(exp_q_l.pop_front()));
            end
        end
    end

    // Idle edge, then bits on edges 1..n. lsb selects the LSB-first instance.
    task automatic send_bits(input logic [9:0] f, input bit lsb, input int n);
        if (lsb) ss_n_l = 1'b0; else ss_n = 1'b0;
        tick();
        for (int i = 1; i <= n; i++) begin
            if (lsb) mosi_l = f[i-1];
            else     mosi   = f[10-i];
            tick();
        end
    endtask

    task automatic send_frame(input logic [9:0] f, input bit lsb);
        if (lsb) exp_q_l.push_back(f); else exp_q.push_back(f);
        send_bits(f, lsb, 10);
    endtask

    task automatic end_frame();
        ss_n   = 1'b1;
        ss_n_l = 1'b1;
        mosi   = 1'b0;
        mosi_l = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [7:0] pat;

    initial begin
        do_reset();
        check("reset_miso", 32'(miso), 32'h0);
        check("reset_rx_data", 32'(rx_data), 32'h0);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_rd_addr_seen", 32'(dut.rd_addr_seen_q), 32'h0);
        check("reset_state", 32'(dut.state_q), 32'h0);

        // 1: write frame, trailing edges ignored
        send_frame(10'h0A5, 1'b0);
        check("wr_rx_data", 32'(rx_data), 32'h0A5);
        tick();
        check("wr_rx_valid_drop", 32'(rx_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            mosi = ~mosi;
            tick();
        end
        check("wr_rd_addr_seen", 32'(dut.rd_addr_seen_q), 32'h0);
        check("wr_miso", 32'(miso), 32'h0);
        end_frame();

        // 2: read address, then read data C3
        send_frame(10'h23C, 1'b0);
        check("ra_rd_addr_seen", 32'(dut.rd_addr_seen_q), 32'h1);
        end_frame();
        send_frame(10'h300, 1'b0);
        tick();
        tick();
        check("rd_wait_miso", 32'(miso), 32'h0);
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        tick();
        tx_data  = 8'h00;       // must be ignored once latched
        pat      = 8'hC3;
        check("rd_miso_b7", 32'(miso), 32'(pat[7]));
        for (int b = 6; b >= 0; b--) begin
            tick();
            check("rd_miso_bit", 32'(miso), 32'(pat[b]));
        end
        tick();
        tx_valid = 1'b0;
        check("rd_miso_after", 32'(miso), 32'h0);
        check("rd_rd_addr_clr", 32'(dut.rd_addr_seen_q), 32'h0);
        tick();
        check("rd_miso_idle", 32'(miso), 32'h0);
        end_frame();

        // 3: read-data command straight from reset takes the address path
        do_reset();
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        send_frame(10'h355, 1'b0);
        check("t3_rx_data", 32'(rx_data), 32'h355);
        check("t3_rd_addr_seen", 32'(dut.rd_addr_seen_q), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_miso_quiet", 32'(miso), 32'h0);
        end
        tx_valid = 1'b0;
        end_frame();

        // 4: abort after 5 bits, then a clean write frame
        send_bits(10'h0FF, 1'b0, 5);
        end_frame();
        check("abort_rx_data", 32'(rx_data), 32'h355);
        check("abort_state", 32'(dut.state_q), 32'h0);
        send_frame(10'h012, 1'b0);
        check("t4_rx_data", 32'(rx_data), 32'h012);
        check("t4_rd_addr_kept", 32'(dut.rd_addr_seen_q), 32'h1);
        end_frame();

        // SS_n rising on the completing edge still delivers the frame
        exp_q.push_back(10'h1C7);
        pat = 8'h00;
        send_bits(10'h1C7, 1'b0, 9);
        mosi = 1'b1;            // bit 10 of 1C7
        ss_n = 1'b1;
        tick();
        check("ssrise_rx_data", 32'(rx_data), 32'h1C7);
        check("ssrise_state", 32'(dut.state_q), 32'h0);

        // 5: reset during read-data shift (address still seen from test 3)
        send_frame(10'h3AA, 1'b0);
        tick();
        tx_data  = 8'hF0;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        tick();
        tick();
        check("t5_miso_b4", 32'(miso), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_miso", 32'(miso), 32'h0);
        check("t5_rx_valid", 32'(rx_valid), 32'h0);
        check("t5_rd_addr_seen", 32'(dut.rd_addr_seen_q), 32'h0);
        check("t5_state", 32'(dut.state_q), 32'h0);
        end_frame();

        // 6: LSB-first instance; first wire bit (bit 0) = 1 selects the read path
        send_frame(10'h2C3, 1'b1);
        check("l_rx_data_addr", 32'(rx_data_l), 32'h2C3);
        check("l_rd_addr_seen", 32'(dut_l.rd_addr_seen_q), 32'h1);
        end_frame();
        send_frame(10'h301, 1'b1);
        check("l_rx_data_rd", 32'(rx_data_l), 32'h301);
        tick();
        tx_data_l  = 8'h01;
        tx_valid_l = 1'b1;
        tick();
        tx_valid_l = 1'b0;
        pat        = 8'h01;
        check("l_miso_b0", 32'(miso_l), 32'(pat[0]));
        for (int b = 1; b < 8; b++) begin
            tick();
            check("l_miso_bit", 32'(miso_l), 32'(pat[b]));
        end
        tick();
        check("l_miso_after", 32'(miso_l), 32'h0);
        check("l_rd_addr_clr", 32'(dut_l.rd_addr_seen_q), 32'h0);
        end_frame();

        tick();
        check("missing_rx_frames", 32'(exp_q.size()), 32'h0);
        check("missing_rx_frames_l", 32'(exp_q_l.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
